// File: rtl/lr_sc_reservation_unit_pkg.sv
// ============================================================================
// Module      : lr_sc_reservation_unit_pkg
// Description : Shared constants and types for the LR/SC reservation unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lr_sc_reservation_unit_pkg;

    localparam int c_DEFAULT_NUM_HARTS  = 16;
    localparam int c_DEFAULT_ADDR_WIDTH = 32;

    // Reservation granule is one 32-bit word, so the two byte-offset bits drop.
    typedef logic [c_DEFAULT_ADDR_WIDTH-3:0] word_addr_t;

    // Value written back to rd by a store-conditional.
    localparam logic c_SC_SUCCESS = 1'b0;
    localparam logic c_SC_FAIL    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lr_sc_reservation_unit_reservation_entry.sv
// ============================================================================
// Module      : reservation_entry
// Description : One hart's reservation: valid bit, word address, match logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reservation_entry #(
    parameter int WORD_WIDTH = 30
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_set,
    input  logic                  i_clear,
    input  logic [WORD_WIDTH-1:0] i_word,
    output logic                  o_valid,
    output logic                  o_match
);

    logic                  r_valid;
    logic [WORD_WIDTH-1:0] r_word;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    // Address is meaningless while invalid, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (i_set) begin
            r_word <= i_word;
        end
    end

    assign o_valid = r_valid;
    assign o_match = r_valid && (r_word == i_word);

endmodule

`default_nettype wire

// File: rtl/lr_sc_reservation_unit.sv
// ============================================================================
// Module      : lr_sc_reservation_unit
// Description : Per-hart LR/SC reservation tracking with registered SC result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lr_sc_reservation_unit
    import lr_sc_reservation_unit_pkg::*;
#(
    parameter int NUM_HARTS  = c_DEFAULT_NUM_HARTS,
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    localparam int HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic [HART_W-1:0]     i_hart_id,
    input  logic                  i_res_station_valid,
    input  logic                  i_store_cond,
    input  logic                  i_mem_wr,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_sc_valid,
    output logic                  o_sc_fail,
    output logic                  o_sc_mem_we,
    output logic [HART_W-1:0]     o_sc_hart_id,
    output logic [NUM_HARTS-1:0]  o_resv_valid
);

    localparam int c_WORD_W = ADDR_WIDTH - 2;

    logic [c_WORD_W-1:0]  w_word;
    logic                 w_unused_byte_offset;
    logic                 w_is_sc;
    logic                 w_is_lr;
    logic                 w_is_st;
    logic                 w_sc_success;
    logic [NUM_HARTS-1:0] w_self;
    logic [NUM_HARTS-1:0] w_match;
    logic [NUM_HARTS-1:0] w_set;
    logic [NUM_HARTS-1:0] w_clear;
    logic [NUM_HARTS-1:0] w_valid;

    logic                 r_sc_valid;
    logic                 r_sc_fail;
    logic                 r_sc_mem_we;
    logic [HART_W-1:0]    r_sc_hart_id;

    assign w_word               = i_addr[ADDR_WIDTH-1:2];
    assign w_unused_byte_offset = ^i_addr[1:0];

    // Only the highest-priority strobe acts: SC, then LR, then plain store.
    assign w_is_sc = i_valid & i_store_cond;
    assign w_is_lr = i_valid & ~i_store_cond & i_res_station_valid;
    assign w_is_st = i_valid & ~i_store_cond & ~i_res_station_valid & i_mem_wr;

    assign w_sc_success = |(w_self & w_match);

    generate
        for (genvar g = 0; g < NUM_HARTS; g++) begin : g_entry
            assign w_self[g]  = (i_hart_id == HART_W'(g));
            assign w_set[g]   = w_is_lr & w_self[g];
            // A successful SC is a store, so it kills every reservation on the word.
            assign w_clear[g] = (w_is_sc & w_self[g])
                              | (w_is_sc & w_sc_success & w_match[g])
                              | (w_is_st & ~w_self[g] & w_match[g]);

            reservation_entry #(
                .WORD_WIDTH (c_WORD_W)
            ) u_entry (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_set     (w_set[g]),
                .i_clear   (w_clear[g]),
                .i_word    (w_word),
                .o_valid   (w_valid[g]),
                .o_match   (w_match[g])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sc_valid   <= 1'b0;
            r_sc_fail    <= 1'b0;
            r_sc_mem_we  <= 1'b0;
            r_sc_hart_id <= '0;
        end else begin
            r_sc_valid  <= w_is_sc;
            r_sc_fail   <= (w_is_sc && !w_sc_success) ? c_SC_FAIL : c_SC_SUCCESS;
            r_sc_mem_we <= w_is_sc & w_sc_success;
            if (w_is_sc) begin
                r_sc_hart_id <= i_hart_id;
            end
        end
    end

    assign o_sc_valid   = r_sc_valid;
    assign o_sc_fail    = r_sc_fail;
    assign o_sc_mem_we  = r_sc_mem_we;
    assign o_sc_hart_id = r_sc_hart_id;
    assign o_resv_valid = w_valid;

endmodule

`default_nettype wire

// File: tb/tb_lr_sc_reservation_unit.sv
// ============================================================================
// Module      : tb_lr_sc_reservation_unit
// Description : Self-checking bench with reservation-table model and directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lr_sc_reservation_unit;

    localparam int c_HARTS = 16;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [3:0]  i_hart_id;
    logic        i_res_station_valid;
    logic        i_store_cond;
    logic        i_mem_wr;
    logic [31:0] i_addr;
    logic        o_sc_valid;
    logic        o_sc_fail;
    logic        o_sc_mem_we;
    logic [3:0]  o_sc_hart_id;
    logic [15:0] o_resv_valid;

    int n_checks = 0;
    int n_fail   = 0;

    lr_sc_reservation_unit dut (
        .i_clk               (clk),
        .i_reset_n           (rst_n),
        .i_valid             (i_valid),
        .i_hart_id           (i_hart_id),
        .i_res_station_valid (i_res_station_valid),
        .i_store_cond        (i_store_cond),
        .i_mem_wr            (i_mem_wr),
        .i_addr              (i_addr),
        .o_sc_valid          (o_sc_valid),
        .o_sc_fail           (o_sc_fail),
        .o_sc_mem_we         (o_sc_mem_we),
        .o_sc_hart_id        (o_sc_hart_id),
        .o_resv_valid        (o_resv_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a table of reservations plus the pending SC result.
    bit          m_valid [c_HARTS];
    logic [29:0] m_word  [c_HARTS];
    bit          e_sc_valid = 0;
    bit          e_sc_fail  = 0;
    bit          e_sc_we    = 0;
    int          e_sc_id    = 0;

    initial begin
        for (int g = 0; g < c_HARTS; g++) begin
            m_valid[g] = 0;
            m_word[g]  = '0;
        end
    end

    always @(negedge rst_n) begin
        for (int g = 0; g < c_HARTS; g++) m_valid[g] = 0;
        e_sc_valid = 0;
        e_sc_fail  = 0;
        e_sc_we    = 0;
        e_sc_id    = 0;
    end

    always @(posedge clk) begin : model_step
        int          h;
        logic [29:0] w;
        bit          ok;
        if (rst_n) begin
            h = int'(i_hart_id);
            w = i_addr[31:2];
            if (i_valid && i_store_cond) begin
                ok = m_valid[h] && (m_word[h] == w);
                if (ok) begin
                    for (int g = 0; g < c_HARTS; g++)
                        if (m_valid[g] && m_word[g] == w) m_valid[g] = 0;
                end
                m_valid[h] = 0;
                e_sc_valid = 1;
                e_sc_fail  = !ok;
                e_sc_we    = ok;
                e_sc_id    = h;
            end else begin
                e_sc_valid = 0;
                e_sc_fail  = 0;
                e_sc_we    = 0;
                if (i_valid && i_res_station_valid) begin
                    m_valid[h] = 1;
                    m_word[h]  = w;
                end else if (i_valid && i_mem_wr) begin
                    for (int g = 0; g < c_HARTS; g++)
                        if (g != h && m_valid[g] && m_word[g] == w) m_valid[g] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] exp_vec;
        for (int g = 0; g < c_HARTS; g++) exp_vec[g] = m_valid[g];
        check("resv_valid", 32'(o_resv_valid), 32'(exp_vec));
        check("sc_valid", 32'(o_sc_valid), 32'(e_sc_valid));
        check("sc_mem_we", 32'(o_sc_mem_we), 32'(e_sc_we));
        if (e_sc_valid) begin
            check("sc_fail", 32'(o_sc_fail), 32'(e_sc_fail));
            check("sc_hart_id", 32'(o_sc_hart_id), 32'(e_sc_id));
        end
    end

    task automatic idle_inputs();
        i_valid             = 1'b0;
        i_store_cond        = 1'b0;
        i_res_station_valid = 1'b0;
        i_mem_wr            = 1'b0;
    endtask

    // Called just after a rising edge; holds the request for exactly one edge.
    task automatic op(input bit v, input bit sc, input bit lr, input bit st,
                      input int h, input logic [31:0] a);
        i_valid             = v;
        i_store_cond        = sc;
        i_res_station_valid = lr;
        i_mem_wr            = st;
        i_hart_id           = 4'(h);
        i_addr              = a;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic lr(input int h, input logic [31:0] a);  op(1, 0, 1, 0, h, a); endtask
    task automatic sc(input int h, input logic [31:0] a);  op(1, 1, 0, 0, h, a); endtask
    task automatic st(input int h, input logic [31:0] a);  op(1, 0, 0, 1, h, a); endtask
    task automatic nop();                                  op(0, 0, 0, 0, 0, 32'h0); endtask

    initial begin
        rst_n     = 1'b0;
        i_hart_id = '0;
        i_addr    = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset resv_valid", 32'(o_resv_valid), 32'h0);
        check("reset sc_valid", 32'(o_sc_valid), 32'h0);
        nop();

        // LR then SC by the same hart succeeds and consumes the reservation.
        lr(3, 32'h100);
        check("lr3 resv", 32'(o_resv_valid[3]), 32'h1);
        sc(3, 32'h100);
        check("sc3 valid", 32'(o_sc_valid), 32'h1);
        check("sc3 fail", 32'(o_sc_fail), 32'h0);
        check("sc3 we", 32'(o_sc_mem_we), 32'h1);
        check("sc3 id", 32'(o_sc_hart_id), 32'h3);
        check("sc3 resv", 32'(o_resv_valid[3]), 32'h0);
        nop();
        check("sc valid drops", 32'(o_sc_valid), 32'h0);

        // Another hart's plain store kills the reservation.
        lr(2, 32'h200);
        st(5, 32'h200);
        sc(2, 32'h200);
        check("sc2 fail", 32'(o_sc_fail), 32'h1);
        check("sc2 we", 32'(o_sc_mem_we), 32'h0);

        // Address mismatch fails and still clears the reservation.
        lr(1, 32'h300);
        sc(1, 32'h304);
        check("sc1 mismatch fail", 32'(o_sc_fail), 32'h1);
        sc(1, 32'h300);
        check("sc1 retry fail", 32'(o_sc_fail), 32'h1);

        // Two-hart race with back-to-back SCs.
        lr(0, 32'h400);
        lr(7, 32'h400);
        sc(0, 32'h400);
        check("race first fail", 32'(o_sc_fail), 32'h0);
        sc(7, 32'h400);
        check("race second valid", 32'(o_sc_valid), 32'h1);
        check("race second fail", 32'(o_sc_fail), 32'h1);
        check("race second id", 32'(o_sc_hart_id), 32'h7);

        // Asynchronous reset between edges.
        lr(4, 32'h500);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset resv", 32'(o_resv_valid), 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sc(4, 32'h500);
        check("sc4 after reset fail", 32'(o_sc_fail), 32'h1);

        // SC in flight when reset asserts leaves no strobe afterwards.
        lr(9, 32'h900);
        i_valid = 1'b1; i_store_cond = 1'b1; i_hart_id = 4'd9; i_addr = 32'h900;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("inflight sc dropped", 32'(o_sc_valid), 32'h0);

        // SC wins over LR in the same cycle.
        op(1, 1, 1, 0, 6, 32'h600);
        check("sc6 prio fail", 32'(o_sc_fail), 32'h1);
        check("sc6 prio resv", 32'(o_resv_valid[6]), 32'h0);

        // Randomized traffic with few harts and words to force collisions.
        for (int n = 0; n < 2000; n++) begin
            bit          v, s, l, w;
            int          h;
            logic [31:0] a;
            v = ($urandom_range(0, 7) != 0);
            s = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 2) == 0);
            h = (n % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            a = 32'h1000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
            op(v, s, l, w, h, a);
        end
        nop();
        nop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
